// File: rtl/gpu_fb_pkg.sv
// Shared framebuffer-writer definitions: screen geometry defaults, write FSM states,
// and the linear address / saturating counter helpers.
package gpu_fb_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_COLOR_W  = 16;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  // Row-major linear address; the caller truncates to its framebuffer address width.
  function automatic logic [31:0] fb_addr(input logic [15:0] x, input logic [15:0] y,
                                          input int unsigned w);
    return 32'(y) * 32'(w) + 32'(x);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write buffer holding {address, colour} entries between the
// clip stage and the memory write FSM.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fragment_fb_writer.sv
// Rasterizer fragment sink: clips to the screen, buffers {addr,colour} writes and drives
// single-beat framebuffer writes over req/ack, pulsing done once a triangle is fully written.
module fragment_fb_writer
  import gpu_fb_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [15:0]        pix_x,
  input  logic [15:0]        pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               raster_done,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [COLOR_W-1:0] mem_wr_data,
  input  logic               mem_wr_ack,
  output logic               done,
  output logic [31:0]        pix_written,
  output logic [31:0]        pix_clipped
);

  localparam int ENTRY_W = ADDR_W + COLOR_W;

  wr_state_e          state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               ready_en_q, ready_en_d;
  logic               pending_q, pending_d;
  logic [31:0]        written_q, written_d;
  logic [31:0]        clipped_q, clipped_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               fifo_push;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               accept;
  logic               clip;
  logic               wr_evt;
  logic               done_now;

  // Held low through reset and the first clock after it so the source sees a clean start.
  assign pix_ready  = ready_en_q & ~fifo_full;
  assign accept     = pix_valid & pix_ready;
  assign clip       = (32'(pix_x) >= 32'(SCREEN_W)) | (32'(pix_y) >= 32'(SCREEN_H));
  assign fifo_push  = accept & ~clip;
  assign fifo_wdata = {ADDR_W'(fb_addr(pix_x, pix_y, SCREEN_W)), pix_color};
  assign wr_evt     = (state_q == WR_WRITE) & mem_wr_ack;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          {addr_d, data_d} = fifo_rdata;
          req_d            = 1'b1;
          state_d          = WR_WRITE;
        end
      end
      WR_WRITE: begin
        // Chain straight into the next entry on ack so a held ack gives one write per cycle.
        if (mem_wr_ack) begin
          if (!fifo_empty) begin
            fifo_pop         = 1'b1;
            {addr_d, data_d} = fifo_rdata;
          end else begin
            req_d   = 1'b0;
            state_d = WR_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_en_d = 1'b1;
    done_now   = pending_q & fifo_empty & (state_q == WR_IDLE) & ~accept;
    pending_d  = start ? raster_done : (raster_done | (pending_q & ~done_now));
    written_d  = start ? 32'd0 : written_q;
    clipped_d  = start ? 32'd0 : clipped_q;
    // The start clear is applied before this cycle's events so they still count.
    if (wr_evt) written_d = sat_inc32(written_d);
    if (accept && clip) clipped_d = sat_inc32(clipped_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WR_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_en_q <= 1'b0;
      pending_q  <= 1'b0;
      written_q  <= '0;
      clipped_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_en_q <= ready_en_d;
      pending_q  <= pending_d;
      written_q  <= written_d;
      clipped_q  <= clipped_d;
    end
  end

  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign done        = done_now;
  assign pix_written = written_q;
  assign pix_clipped = clipped_q;

endmodule

// File: tb/tb_fragment_fb_writer.sv
// Self-checking bench for fragment_fb_writer: directed corner sequences, a vector table,
// and a randomized run scored against a queue-based write model.
module tb_fragment_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [15:0] pix_x = '0;
  logic [15:0] pix_y = '0;
  logic [15:0] pix_color = '0;
  logic        raster_done = 1'b0;
  logic        mem_wr_req;
  logic [18:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        mem_wr_ack = 1'b0;
  logic        done;
  logic [31:0] pix_written;
  logic [31:0] pix_clipped;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] color;
    bit          clip;
    logic [18:0] addr;
  } vec_t;

  wr_t    m_q[$];
  longint m_written = 0;
  longint m_clipped = 0;
  bit     m_pend = 1'b0;

  fragment_fb_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .raster_done (raster_done),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ack  (mem_wr_ack),
    .done        (done),
    .pix_written (pix_written),
    .pix_clipped (pix_clipped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle with the given inputs; pulse inputs drop after the edge.
  task automatic applyStimulus(input bit v, input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] c, input bit rd, input bit st, input bit ack);
    pix_valid = v; pix_x = x; pix_y = y; pix_color = c;
    raster_done = rd; start = st; mem_wr_ack = ack;
    @(posedge clk); #1;
    raster_done = 1'b0; start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sendPix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                         input bit rd);
    bit ok = 1'b0;
    pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = c;
    for (int i = 0; i < 60; i++) begin
      if (pix_ready) begin
        raster_done = rd;
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    pix_valid = 1'b0; raster_done = 1'b0;
    if (!ok) checkOutput("send_timeout", 0, 1);
  endtask

  task automatic waitReq(input bit level, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mem_wr_req == level) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) checkOutput(name, 0, 1);
  endtask

  // Reference model: a queue of outstanding writes plus plain counters and a pending flag.
  always @(negedge clk) begin
    bit  acc;
    bit  exp_done;
    wr_t e;
    longint a;
    if (!rst_n) begin
      m_q.delete();
      m_written = 0;
      m_clipped = 0;
      m_pend = 1'b0;
    end else if (mon_en) begin
      acc = pix_valid & pix_ready;
      checkOutput("mon_written", pix_written, m_written);
      checkOutput("mon_clipped", pix_clipped, m_clipped);
      exp_done = m_pend && (m_q.size() == 0) && !acc;
      checkOutput("mon_done", done, exp_done);
      if (start) begin m_written = 0; m_clipped = 0; end
      if (mem_wr_req && mem_wr_ack) begin
        if (m_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("[TB] FAIL mon_write: got write to %0h, expected no write", mem_wr_addr);
        end else begin
          e = m_q.pop_front();
          checkOutput("mon_addr", mem_wr_addr, e.addr);
          checkOutput("mon_data", mem_wr_data, e.data);
        end
        if (m_written < 64'hFFFF_FFFF) m_written++;
      end
      if (acc) begin
        if (pix_x >= 640 || pix_y >= 480) begin
          if (m_clipped < 64'hFFFF_FFFF) m_clipped++;
        end else begin
          a = longint'(pix_y) * 640 + longint'(pix_x);
          e.addr = a[18:0];
          e.data = pix_color;
          m_q.push_back(e);
        end
      end
      m_pend = start ? raster_done : (raster_done || (m_pend && !exp_done));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    bit   got;
    logic [18:0] ga;
    logic [15:0] gd;
    int   nwr;
    bit   contig;
    bit   seen_end;
    bit   acc_prev;
    bit   hold;

    vecs[0] = '{16'd3,     16'd2,   16'hF800, 1'b0, 19'd1283};
    vecs[1] = '{16'd0,     16'd0,   16'h0001, 1'b0, 19'd0};
    vecs[2] = '{16'd639,   16'd479, 16'h07E0, 1'b0, 19'd307199};
    vecs[3] = '{16'd639,   16'd0,   16'h001F, 1'b0, 19'd639};
    vecs[4] = '{16'd0,     16'd1,   16'hABCD, 1'b0, 19'd640};
    vecs[5] = '{16'd100,   16'd200, 16'h1234, 1'b0, 19'd128100};
    vecs[6] = '{16'd0,     16'd479, 16'h5555, 1'b0, 19'd306560};
    vecs[7] = '{16'd640,   16'd0,   16'hFFFF, 1'b1, 19'd0};
    vecs[8] = '{16'd0,     16'd480, 16'hFFFF, 1'b1, 19'd0};
    vecs[9] = '{16'd65535, 16'd5,   16'hFFFF, 1'b1, 19'd0};

    // Reset state and ready release.
    #12;
    checkOutput("rst_ready", pix_ready, 0);
    checkOutput("rst_req", mem_wr_req, 0);
    checkOutput("rst_addr", mem_wr_addr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_written", pix_written, 0);
    #10 rst_n = 1'b1;
    #1 checkOutput("rel_ready_low", pix_ready, 0);
    tick();
    checkOutput("rel_ready_high", pix_ready, 1);

    // Reset in the middle of a write.
    mem_wr_ack = 1'b0;
    sendPix(16'd5, 16'd5, 16'h00AA, 1'b0);
    waitReq(1'b1, "t1_req_timeout");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_req", mem_wr_req, 0);
    checkOutput("t1_addr", mem_wr_addr, 0);
    checkOutput("t1_data", mem_wr_data, 0);
    checkOutput("t1_ready", pix_ready, 0);
    checkOutput("t1_written", pix_written, 0);
    checkOutput("t1_clipped", pix_clipped, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    tick();
    checkOutput("t1_ready_after", pix_ready, 1);

    // Single fragment, ack held.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    sendPix(16'd3, 16'd2, 16'hF800, 1'b0);
    checkOutput("t2_req_latency", mem_wr_req, 0);
    tick();
    checkOutput("t2_req", mem_wr_req, 1);
    checkOutput("t2_addr", mem_wr_addr, 1283);
    checkOutput("t2_data", mem_wr_data, 16'hF800);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_written", pix_written, 1);
    tick();
    checkOutput("t2_done_pulse", done, 0);

    // Clipping and done with nothing outstanding.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    sendPix(16'd640, 16'd0, 16'h1111, 1'b0);
    sendPix(16'd0, 16'd480, 16'h2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_no_req", mem_wr_req, 0);
      tick();
    end
    checkOutput("t3_clipped", pix_clipped, 2);
    checkOutput("t3_written", pix_written, 0);
    raster_done = 1'b1;
    #1 checkOutput("t3_done_early", done, 0);
    tick();
    raster_done = 1'b0;
    checkOutput("t3_done", done, 1);
    tick();
    checkOutput("t3_done_pulse", done, 0);

    // Backpressure: 4 queued plus 1 in flight, then back-to-back drain.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) sendPix(16'(i * 7), 16'd5, 16'(16'h0100 + i), 1'b0);
    checkOutput("t4_ready_full", pix_ready, 0);
    pix_valid = 1'b1; pix_x = 16'd50; pix_y = 16'd6; pix_color = 16'h0105;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t4_ready_held", pix_ready, 0);
    end
    checkOutput("t4_first_addr", mem_wr_addr, 19'd3200);
    mem_wr_ack = 1'b1;
    nwr = 0; contig = 1'b1; seen_end = 1'b0;
    for (int i = 0; i < 10; i++) begin
      acc_prev = pix_valid & pix_ready;
      if (mem_wr_req) begin
        nwr++;
        if (seen_end) contig = 1'b0;
      end else if (nwr > 0) begin
        seen_end = 1'b1;
      end
      tick();
      if (acc_prev) pix_valid = 1'b0;
    end
    checkOutput("t4_writes", nwr, 6);
    checkOutput("t4_back_to_back", contig, 1);
    checkOutput("t4_written", pix_written, 6);

    // raster_done with the last accept, ack delayed.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    sendPix(16'd10, 16'd10, 16'h0A0A, 1'b0);
    sendPix(16'd11, 16'd10, 16'h0B0B, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_done_wait", done, 0);
      tick();
    end
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!mem_wr_req) break;
      checkOutput("t5_done_during", done, 0);
      tick();
    end
    checkOutput("t5_done", done, 1);
    checkOutput("t5_written", pix_written, 2);
    tick();
    mem_wr_ack = 1'b0;

    // Vector table, one fragment per entry.
    foreach (vecs[i]) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      sendPix(vecs[i].x, vecs[i].y, vecs[i].color, 1'b0);
      got = 1'b0; ga = '0; gd = '0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (mem_wr_req && mem_wr_ack && !got) begin
          got = 1'b1; ga = mem_wr_addr; gd = mem_wr_data;
        end
      end
      tick();
      checkOutput("vec_write_seen", got, !vecs[i].clip);
      if (!vecs[i].clip) begin
        checkOutput("vec_addr", ga, vecs[i].addr);
        checkOutput("vec_data", gd, vecs[i].color);
      end
      checkOutput("vec_clipped", pix_clipped, vecs[i].clip);
      checkOutput("vec_written", pix_written, !vecs[i].clip);
    end

    // start coincident with an ack after 10 writes, and with a clipped accept.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) sendPix(16'(i), 16'd20, 16'(i), 1'b0);
    waitReq(1'b0, "t6_drain_timeout");
    tick();
    checkOutput("t6_written10", pix_written, 10);
    mem_wr_ack = 1'b0;
    sendPix(16'd30, 16'd30, 16'h3030, 1'b0);
    waitReq(1'b1, "t6_req_timeout");
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    mem_wr_ack = 1'b0;
    checkOutput("t6_start_ack", pix_written, 1);
    applyStimulus(1, 16'd700, 16'd0, 16'h0, 0, 1, 0);
    pix_valid = 1'b0;
    checkOutput("t6_start_clip", pix_clipped, 1);

    // Randomized traffic against the model.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      acc_prev = pix_valid & pix_ready;
      if (!(pix_valid && !acc_prev)) begin
        hold = ($urandom_range(0, 2) != 0);
        pix_x = 16'($urandom_range(0, 720));
        pix_y = 16'($urandom_range(0, 540));
        pix_color = 16'($urandom);
      end
      applyStimulus(hold, pix_x, pix_y, pix_color, ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6));
    end
    // Drain and expect a completion pulse.
    applyStimulus(pix_valid & ~pix_ready, pix_x, pix_y, pix_color, 0, 0, 1);
    for (int i = 0; i < 20 && pix_valid; i++) begin
      acc_prev = pix_ready;
      tick();
      if (acc_prev) pix_valid = 1'b0;
    end
    pix_valid = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1'b1; break; end
      tick();
    end
    checkOutput("rand_done_seen", got, 1);
    tick();

    // Saturation of the written counter.
    mon_en = 1'b0;
    mem_wr_ack = 1'b0;
    sendPix(16'd1, 16'd1, 16'h0001, 1'b0);
    sendPix(16'd2, 16'd1, 16'h0002, 1'b0);
    waitReq(1'b1, "sat_req_timeout");
    force dut.written_d = 32'hFFFF_FFFE;
    tick();
    release dut.written_d;
    checkOutput("sat_preload", pix_written, 32'hFFFF_FFFE);
    mem_wr_ack = 1'b1;
    tick();
    checkOutput("sat_max", pix_written, 32'hFFFF_FFFF);
    tick();
    checkOutput("sat_hold", pix_written, 32'hFFFF_FFFF);
    mem_wr_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
